enc4_2_serializer: RTL and testbench
====================================

Name: enc4_2_serializer

Overview:
- Encoder-side counterpart of the team's 2-to-4 decoder.
- Accepts a 4-bit request vector, which may have several bits set, over a valid/ready handshake.
- Emits the 2-bit binary index of each set bit, one index per handshake beat, lowest index first, and flags the final beat.
- Sits in front of a 2-to-4 decoder: decoding each emitted code reproduces the original vector one bit at a time.

Parameters:
- N, 4, width of the request vector (must be a power of 2, at least 2).
- W, 2, code width, equal to log2(N).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_vec  input  N  request vector; bit i set means code i is to be emitted.
- in_valid  input  1  in_vec is valid this cycle.
- in_ready  output  1  block can accept a vector this cycle.
- out_code  output  W  binary index of the lowest pending bit.
- out_valid  output  1  out_code/out_last are valid.
- out_ready  input  1  downstream accepts the current beat.
- out_last  output  1  current beat is the final set bit of the vector.
- zero_err  output  1  one-cycle pulse: an all-zero vector was accepted.

Behaviour:
- State: FSM {IDLE, BUSY}; pend register, N bits.
- Reset, when rst is sampled high:
  - state=IDLE, pend=0.
  - Outputs: out_valid=0, out_last=0, zero_err=0, in_ready=1, out_code=0.
  - Reset overrides any handshake in the same cycle; a beat pending mid-vector is discarded.
- in_ready:
  - Is 1 only in IDLE.
  - Depends only on state; no combinational path from out_ready.
- Accept in IDLE (in_valid=1):
  - Nonzero vector: pend<=in_vec, state<=BUSY.
  - All-zero vector: state stays IDLE, zero_err=1 for exactly the next cycle; nothing is emitted.
- Outputs from registers:
  - out_valid = (state==BUSY).
  - out_code = index of the least-significant set bit of pend.
  - out_last = 1 iff pend has exactly one bit set.
  - All three are combinational from registers only.
- Latency: first beat is valid the cycle after acceptance.
  - No back-to-back: the earliest next acceptance is the cycle after the last beat completes.
- Beat completion (BUSY, out_valid & out_ready):
  - The bit at out_code is cleared in pend.
  - If out_last=1, state<=IDLE and pend becomes 0.
  - Otherwise stay in BUSY; the next code appears the following cycle.
- Stall (BUSY, out_ready=0): out_code, out_last, out_valid are held stable; pend is unchanged.
- Throughput: one code per cycle while out_ready=1. A vector with k set bits takes k cycles in BUSY.
- Inputs ignored in BUSY: in_vec and in_valid have no effect; in_vec changes there are not captured.
- zero_err is registered; it never asserts together with out_valid from the same vector.
- Ordering is strictly ascending index; no reordering and no fairness beyond that.
- No X propagation: out_code=0 whenever out_valid=0.

Test Plan:
- Reset behaviour:
  - Stimulus: assert rst 2 cycles with in_valid=1, in_vec=4'b1111.
  - Required: in_ready=1, out_valid=0, zero_err=0 throughout; no capture occurs.
- One-hot sweep:
  - Stimulus: in_vec=0001, 0010, 0100, 1000, each with out_ready=1.
  - Required: single beats with out_code 0,1,2,3 respectively, each with out_last=1, one cycle after accept. The same codes fed to dec2_4 with en=1 reproduce each in_vec.
- Multi-hot serialization:
  - Stimulus: in_vec=4'b1011, out_ready=1.
  - Required: beats on consecutive cycles with out_code=0,1,3 and out_last=0,0,1. in_ready returns high on the cycle after code 3.
- Backpressure:
  - Stimulus: in_vec=4'b0110; hold out_ready=0 for 3 cycles, then 1.
  - Required: out_code=1 and out_last=0 held stable for 4 cycles, then out_code=2 with out_last=1.
  - During BUSY, in_valid=1 with in_vec=1111 is ignored (in_ready=0).
- Zero vector:
  - Stimulus: in_vec=0000 with in_valid=1.
  - Required: zero_err pulses high exactly 1 cycle; out_valid stays 0; in_ready stays 1.
- Reset mid-operation:
  - Stimulus: in_vec=1111 accepted, 2 beats taken, then rst for 1 cycle.
  - Required: next cycle state is IDLE, out_valid=0, in_ready=1. A new vector 0100 then yields a single beat, out_code=2, out_last=1.

Source files
------------

// File: rtl/enc4_2_serializer.sv
// enc4_2_serializer
//   Accepts an N-bit request vector over a valid/ready handshake and emits
//   the W-bit binary index of every set bit, lowest index first, one index
//   per output beat.
//   Feeding each emitted code into a W-to-N decoder rebuilds the original
//   vector one bit at a time.
//   An all-zero vector is accepted but emits no beats. Instead, it raises a
//   one-cycle zero_err pulse.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_vec     request vector; bit i set -> code i is emitted
//   in_valid   in_vec is valid this cycle
//   in_ready   block can accept a vector (IDLE only)
//   out_code   index of the lowest pending bit (0 when out_valid=0)
//   out_valid  out_code / out_last are valid
//   out_ready  downstream accepts the current beat
//   out_last   current beat is the final set bit of the vector
//   zero_err   one-cycle pulse after an all-zero vector was accepted
module enc4_2_serializer #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_vec,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_code,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         zero_err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t       state, state_next;
  logic [N-1:0] pend, pend_next;
  logic         zero_err_next;
  logic [N-1:0] pend_low_cleared;

  // Clearing the lowest set bit is the classic x & (x - 1).
  // It also tells us whether pend holds exactly one bit.
  assign pend_low_cleared = pend & (pend - N'(1));

  // Outputs depend on registers only. They do not depend on out_ready or
  // any other input.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == BUSY);
  assign out_last  = (state == BUSY) && (pend != '0) && (pend_low_cleared == '0);

  // Priority encoder: scan from the top down so the lowest set bit is
  // written last and wins. The result is gated so it is 0 outside BUSY.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first. Without the default, some path leaves it unassigned and a
    // latch is inferred.
    out_code = '0;
    if (state == BUSY) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (pend[i]) out_code = W'(i);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next    = state;
    pend_next     = pend;
    zero_err_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_vec == '0) begin
            zero_err_next = 1'b1;
          end else begin
            pend_next  = in_vec;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (out_ready) begin
          // The lowest set bit is the one just emitted. On the last beat
          // this clears pend to zero.
          pend_next = pend_low_cleared;
          if (out_last) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the pre-edge values, regardless of statement order.
    if (rst) begin
      state    <= IDLE;
      pend     <= '0;
      zero_err <= 1'b0;
    end else begin
      state    <= state_next;
      pend     <= pend_next;
      zero_err <= zero_err_next;
    end
  end

endmodule

// File: tb/tb_enc4_2_serializer.sv
// Directed self-checking bench for enc4_2_serializer.
// Inputs are driven 1 ns after each rising edge, and outputs are sampled at
// that same point. The sample reflects the state registered at that edge.
module tb_enc4_2_serializer;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] in_vec;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_code;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         zero_err;

  int checks = 0;
  int errors = 0;

  enc4_2_serializer #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_vec    (in_vec),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_code  (out_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .zero_err  (zero_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference 2-to-4 decoder used to rebuild vectors from emitted codes.
  function automatic logic [N-1:0] dec2_4(input logic [W-1:0] code);
    return N'(1) << code;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".in_ready"},  32'(in_ready),  32'd1);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".out_code"},  32'(out_code),  32'd0);
  endtask

  task automatic check_beat(input string tag, input int code, input bit last);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".in_ready"},  32'(in_ready),  32'd0);
    check({tag, ".out_code"},  32'(out_code),  32'(code));
    check({tag, ".out_last"},  32'(out_last),  32'(last));
  endtask

  // Multi-hot vector 1011: expected beats, in order.
  int          mh_code [3] = '{0, 1, 3};
  bit          mh_last [3] = '{1'b0, 1'b0, 1'b1};
  logic [N-1:0] rebuilt;

  initial begin
    // Reset held for two cycles while a full vector is offered.
    rst = 1'b1; in_valid = 1'b1; in_vec = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_idle("reset");
      check("reset.zero_err", 32'(zero_err), 32'd0);
    end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    check_idle("post_reset");

    // One-hot sweep.
    for (int i = 0; i < N; i++) begin
      in_vec = N'(1) << i; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check_beat("onehot", i, 1'b1);
      check("onehot.dec", 32'(dec2_4(out_code)), 32'(in_vec));
      tick();
      check_idle("onehot_done");
    end

    // Multi-hot serialization, with reconstruction through the decoder.
    in_vec = 4'b1011; in_valid = 1'b1; rebuilt = '0;
    tick();
    in_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      check_beat("multi", mh_code[b], mh_last[b]);
      rebuilt |= dec2_4(out_code);
      tick();
    end
    check("multi.rebuilt", 32'(rebuilt), 32'b1011);
    check_idle("multi_done");

    // Backpressure: a stalled beat is held for 4 cycles, and a vector
    // offered during BUSY is ignored.
    out_ready = 1'b0; in_vec = 4'b0110; in_valid = 1'b1;
    tick();
    in_vec = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      check_beat("stall", 1, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    check_beat("stall_release", 1, 1'b0);
    tick();
    check_beat("stall_second", 2, 1'b1);
    in_valid = 1'b0;
    tick();
    check_idle("stall_done");
    tick();
    check_idle("stall_no_capture");

    // Zero vector.
    in_vec = 4'b0000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("zero.zero_err", 32'(zero_err), 32'd1);
    check_idle("zero");
    tick();
    check("zero.pulse_end", 32'(zero_err), 32'd0);
    check_idle("zero_after");

    // Reset in the middle of a vector.
    in_vec = 4'b1111; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_beat("midrst0", 0, 1'b0);
    tick();
    check_beat("midrst1", 1, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("midrst_reset");
    check("midrst.out_last", 32'(out_last), 32'd0);
    in_vec = 4'b0100; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_beat("midrst_new", 2, 1'b1);
    tick();
    check_idle("midrst_done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
